// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one nibble per clock on a single
// shared 4-bit ripple-carry slice, LSB nibble first, under a start/done
// handshake.
// Optional feature macro: NSA_SUBTRACT_EN (adds the `sub` port for a - b).

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_start,
`ifdef NSA_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             c_q, c_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic [3:0]       a_nibs [NIB];
  logic [3:0]       b_nibs [NIB];
  logic [3:0]       nib_a, nib_b, nib_sum;
  logic             nib_cout;
  logic             last_nib;

  // Split the latched operands into nibbles so the slice input is a plain mux.
  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nibs[gi] = a_q[4*gi +: 4];
      assign b_nibs[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  assign nib_a    = a_nibs[idx_q];
  assign nib_b    = b_nibs[idx_q];
  assign last_nib = (idx_q == IW'(NIB - 1));

  // The one and only adder slice, time-shared across all nibbles.
  rca_4bit u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (c_q),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // State register plus all datapath registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN until last nibble, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_nib) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture in IDLE, one nibble per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          c_d   = carry_start;
          idx_d = '0;
`ifdef NSA_SUBTRACT_EN
          // Two's-complement subtract: a + ~b + 1, so carry=1 means no borrow.
          if (sub) begin
            b_d = ~b;
            c_d = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) work_d[4*i +: 4] = nib_sum;
        end
        c_d = nib_cout;
        if (last_nib) begin
          // On the last nibble work_d already holds every finished nibble.
          sum_d   = work_d;
          carry_d = nib_cout;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs: handshake decoded from state, results straight from registers.
  always_comb begin
    busy  = (state_q == S_RUN) || (state_q == S_DONE);
    done  = (state_q == S_DONE);
    sum   = sum_q;
    carry = carry_q;
  end

endmodule

// rca_4bit: plain 4-bit ripple-carry adder slice.
module rca_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];

endmodule
